// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage: takes WIDTH-bit words over valid/ready and emits one bit per
// enabled clock with a per-bit strobe and an end-of-frame pulse; back-to-back words have no gap.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             data,
  output logic             bit_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             data_q, data_d;
  logic             bv_q, bv_d;
  logic             fd_q, fd_d;
  logic             accept;

  // cnt_q is the index of the bit currently on data; sr_q holds the bits not yet emitted,
  // aligned so the next one always sits at the emit end.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    bv_d      = 1'b0;
    fd_d      = 1'b0;
    din_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST) && shift_en);
    accept    = din_valid && din_ready;

    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      bv_d    = 1'b1;
      data_d  = MSB_FIRST ? din[WIDTH-1] : din[0];
      sr_d    = MSB_FIRST ? (din << 1) : (din >> 1);
    end else if (state_q == SHIFT) begin
      if (shift_en) begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          data_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          bv_d   = 1'b1;
          fd_d   = (cnt_q == PENULT);
          data_d = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
          sr_d   = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        end
      end
    end else begin
      data_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      bv_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      bv_q    <= bv_d;
      fd_q    <= fd_d;
    end
  end

  assign data       = data_q;
  assign bit_valid  = bv_q;
  assign frame_done = fd_q;
  assign busy       = (state_q == SHIFT);

endmodule
